// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM from one shared counter, debounced duty buttons
// Duty and alignment mode are shadow-latched at period boundaries for glitch-free updates.
module pwm_multi_channel #(
   parameter int CHANNELS  = 4,
   parameter int CNT_W     = 8,
   parameter int PERIOD    = 10,
   parameter int STEP      = 1,
   parameter int DUTY_INIT = 5,
   parameter int DEB_DIV   = 25000000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic [CHANNELS-1:0]       inc_btn,
   input  logic [CHANNELS-1:0]       dec_btn,
   input  logic                      wr_en,
   input  logic [2:0]                wr_ch,
   input  logic [CNT_W-1:0]          wr_duty,
   input  logic                      center_mode,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic [CHANNELS*CNT_W-1:0] duty_out,
   output logic                      period_start
);

   localparam int              TW       = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
   localparam logic [TW-1:0]   TICK_MAX = TW'(DEB_DIV - 1);
   localparam logic [CNT_W-1:0] PER     = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] PER_M1  = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] STP     = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] DINIT   = CNT_W'(DUTY_INIT);

   typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

   logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
   logic                tick;
   logic [CHANNELS-1:0] inc_s1_q, inc_s2_q, dec_s1_q, dec_s2_q;
   logic [CHANNELS-1:0] inc_press, dec_press;

   logic [CNT_W-1:0]    duty_q   [CHANNELS];
   logic [CNT_W-1:0]    duty_d   [CHANNELS];
   logic [CNT_W-1:0]    shadow_q [CHANNELS];
   logic                mode_sh_q;

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   dir_e                dir_q, dir_d;
   logic                boundary;
   logic                first_q;
   logic [CHANNELS-1:0] pwm_q, pwm_d;
   logic                period_start_q;

   assign tick       = (tick_cnt_q == TICK_MAX);
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt_q <= '0;
         inc_s1_q   <= '0;
         inc_s2_q   <= '0;
         dec_s1_q   <= '0;
         dec_s2_q   <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         if (tick) begin
            inc_s1_q <= inc_btn;
            inc_s2_q <= inc_s1_q;
            dec_s1_q <= dec_btn;
            dec_s2_q <= dec_s1_q;
         end
      end
   end

   assign inc_press = inc_s1_q & ~inc_s2_q & {CHANNELS{tick}};
   assign dec_press = dec_s1_q & ~dec_s2_q & {CHANNELS{tick}};

   // A direct write wins over any button press landing in the same cycle.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         duty_d[i] = duty_q[i];
         if (wr_en && (wr_ch == 3'(i))) begin
            duty_d[i] = (wr_duty > PER) ? PER : wr_duty;
         end else if (inc_press[i] && dec_press[i]) begin
            duty_d[i] = duty_q[i];
         end else if (inc_press[i]) begin
            duty_d[i] = (duty_q[i] <= PER - STP) ? duty_q[i] + STP : PER;
         end else if (dec_press[i]) begin
            duty_d[i] = (duty_q[i] >= STP) ? duty_q[i] - STP : '0;
         end
      end
   end

   // Center mode holds each end value twice so the up and down halves are symmetric.
   always_comb begin
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      boundary = 1'b0;
      if (!ena) begin
         cnt_d    = '0;
         dir_d    = DIR_UP;
         boundary = 1'b1;
      end else if (!mode_sh_q) begin
         if (cnt_q == PER_M1) begin
            cnt_d    = '0;
            dir_d    = DIR_UP;
            boundary = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (dir_q == DIR_UP) begin
         if (cnt_q == PER_M1) dir_d = DIR_DOWN;
         else                 cnt_d = cnt_q + CNT_W'(1);
      end else begin
         if (cnt_q == '0) begin
            dir_d    = DIR_UP;
            boundary = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_d[i] = ena && (cnt_q < shadow_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            duty_q[i]   <= DINIT;
            shadow_q[i] <= DINIT;
         end
         mode_sh_q      <= 1'b0;
         cnt_q          <= '0;
         dir_q          <= DIR_UP;
         first_q        <= 1'b1;
         pwm_q          <= '0;
         period_start_q <= 1'b0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            duty_q[i] <= duty_d[i];
            if (boundary) shadow_q[i] <= duty_q[i];
         end
         if (boundary) mode_sh_q <= center_mode;
         cnt_q          <= cnt_d;
         dir_q          <= dir_d;
         first_q        <= boundary;
         pwm_q          <= pwm_d;
         period_start_q <= ena & first_q;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_duty_out
      assign duty_out[g*CNT_W +: CNT_W] = duty_q[g];
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb/tb_pwm_multi_channel.sv - scoreboard bench for pwm_multi_channel
module tb_pwm_multi_channel;
   localparam int CH = 4;
   localparam int W  = 8;
   localparam int P  = 10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ena = 1'b0;
   logic [CH-1:0]   inc_btn = '0;
   logic [CH-1:0]   dec_btn = '0;
   logic            wr_en = 1'b0;
   logic [2:0]      wr_ch = '0;
   logic [W-1:0]    wr_duty = '0;
   logic            center_mode = 1'b0;
   logic [CH-1:0]   pwm_out;
   logic [CH*W-1:0] duty_out;
   logic            period_start;

   int checks = 0;
   int errors = 0;
   int ed [CH];

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sb [$];

   pwm_multi_channel #(
      .CHANNELS(CH), .CNT_W(W), .PERIOD(P), .STEP(1), .DUTY_INIT(5), .DEB_DIV(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .inc_btn(inc_btn), .dec_btn(dec_btn),
      .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty), .center_mode(center_mode),
      .pwm_out(pwm_out), .duty_out(duty_out), .period_start(period_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_duties(input string tag);
      for (int i = 0; i < CH; i++) begin
         check($sformatf("%s_duty%0d", tag, i), 32'(duty_out[i*W +: W]), 32'(ed[i]));
      end
   endtask

   task automatic wait_ps();
      int n = 0;
      repeat (2) @(negedge clk);
      while (period_start !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (period_start !== 1'b1) check("ps_timeout", 32'(period_start), 32'd1);
   endtask

   // Expected {period_start, pwm} per cycle, derived from duty d and the alignment mode.
   task automatic run_pattern(input int ch, input int d, input bit center, input int nper);
      int len = center ? 2*P : P;
      bit hi;
      for (int p = 0; p < nper; p++) begin
         for (int k = 0; k < len; k++) begin
            hi = center ? (k < d || k >= len - d) : (k < d);
            sb.push_back('{$sformatf("pat_ch%0d_d%0d_c%0d_k%0d", ch, d, center, k),
                           {30'b0, (k == 0), hi}});
         end
      end
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check(e.tag, {30'b0, period_start, pwm_out[ch]}, e.exp);
         @(negedge clk);
      end
   endtask

   task automatic press(input logic [CH-1:0] inc, input logic [CH-1:0] dec);
      inc_btn = inc;
      dec_btn = dec;
      repeat (6) @(negedge clk);
      inc_btn = '0;
      dec_btn = '0;
      repeat (6) @(negedge clk);
   endtask

   task automatic write1(input logic [2:0] ch, input logic [W-1:0] val);
      wr_en   = 1'b1;
      wr_ch   = ch;
      wr_duty = val;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      rst_n = 1'b0;
      ena   = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < CH; i++) ed[i] = 5;
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_ps", 32'(period_start), 32'd0);
      check_duties("rst");
      rst_n = 1'b1;

      wait_ps();
      run_pattern(0, 5, 1'b0, 2);

      press(4'b0010, 4'b0000);
      ed[1] = 6;
      check_duties("inc1");
      wait_ps();
      run_pattern(1, 6, 1'b0, 1);
      run_pattern(0, 5, 1'b0, 1);

      repeat (7) press(4'b0001, 4'b0000);
      ed[0] = 10;
      check_duties("sat_hi");
      wait_ps();
      run_pattern(0, 10, 1'b0, 2);

      repeat (12) press(4'b0000, 4'b0001);
      ed[0] = 0;
      check_duties("sat_lo");
      wait_ps();
      run_pattern(0, 0, 1'b0, 2);

      press(4'b0100, 4'b0100);
      check_duties("incdec");

      wr_en = 1'b1; wr_ch = 3'd2; wr_duty = 8'd7;
      press(4'b0100, 4'b0000);
      wr_en = 1'b0;
      ed[2] = 7;
      check_duties("wr_beats_inc");

      wr_en = 1'b1; wr_ch = 3'd2; wr_duty = 8'd200;
      press(4'b0100, 4'b0000);
      wr_en = 1'b0;
      ed[2] = 10;
      check_duties("wr_clamp");

      write1(3'd5, 8'd1);
      @(negedge clk);
      check_duties("wr_bad_ch");

      write1(3'd3, 8'd3);
      ed[3] = 3;
      @(negedge clk);
      check_duties("wr_ch3");

      center_mode = 1'b1;
      repeat (2) @(negedge clk);
      wait_ps();
      run_pattern(3, 3, 1'b1, 2);
      center_mode = 1'b0;
      run_pattern(3, 3, 1'b1, 1);
      run_pattern(3, 3, 1'b0, 1);

      repeat (3) @(negedge clk);
      check("pre_ena_pwm", 32'(pwm_out), 32'b0110);
      ena = 1'b0;
      @(negedge clk);
      check("ena_low_pwm", 32'(pwm_out), 32'd0);
      write1(3'd1, 8'd2);
      ed[1] = 2;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ena_low_pwm_%0d", i), 32'(pwm_out), 32'd0);
         check($sformatf("ena_low_ps_%0d", i), 32'(period_start), 32'd0);
         @(negedge clk);
      end
      check_duties("ena_low_wr");
      ena = 1'b1;
      @(negedge clk);
      run_pattern(1, 2, 1'b0, 1);

      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      for (int i = 0; i < CH; i++) ed[i] = 5;
      check("midrst_pwm", 32'(pwm_out), 32'd0);
      check("midrst_ps", 32'(period_start), 32'd0);
      check_duties("midrst");
      rst_n = 1'b1;
      wait_ps();
      run_pattern(0, 5, 1'b0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_multi_channel.md
Name: pwm_multi_channel

Overview:
- Parametrised successor to the single-channel button-controlled PWM generator.
- Drives CHANNELS independent PWM outputs from one shared period counter.
- Each channel's duty is adjusted by its own debounced inc/dec buttons, or loaded directly through a write port.
- Adds edge- or center-aligned mode and glitch-free duty updates. Duty and mode are shadow-latched at period boundaries.

Parameters:
- CHANNELS, 4, number of PWM outputs (1..8)
- CNT_W, 8, width of the period counter and duty registers
- PERIOD, 10, PWM period in counts (2..2^CNT_W-1); duty range is 0..PERIOD
- STEP, 1, duty change per debounced button press (1..PERIOD)
- DUTY_INIT, 5, reset duty for every channel (0..PERIOD)
- DEB_DIV, 25000000, clocks per debounce sample tick (>=1; 2 for simulation)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  enable; low freezes PWM and forces outputs low
- inc_btn  in  CHANNELS  raw increase buttons, one per channel
- dec_btn  in  CHANNELS  raw decrease buttons, one per channel
- wr_en  in  1  direct duty write strobe
- wr_ch  in  3  channel index for the write
- wr_duty  in  CNT_W  duty value for the write
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned
- pwm_out  out  CHANNELS  registered PWM outputs
- duty_out  out  CHANNELS*CNT_W  current (pre-shadow) duty registers, channel 0 in the LSBs
- period_start  out  1  one-cycle pulse at the first count of each period

Behaviour:
- Reset (rst_n low at a clk edge):
  - tick counter = 0; all debounce FFs = 0
  - duty[i] = shadow[i] = DUTY_INIT; mode_sh = 0; cnt = 0; dir = up
  - pwm_out = 0; period_start = 0
  - Reset mid-period aborts the period immediately.
- Tick generator:
  - Counts 0..DEB_DIV-1 and wraps.
  - tick = 1 for the single cycle where count == DEB_DIV-1.
  - Runs regardless of ena.
- Debounce, per channel and per button:
  - s1 <= btn and s2 <= s1, updated only on tick.
  - press = s1 & ~s2 & tick: one pulse per press, lasting one cycle.
- Duty update, per channel, priority order:
  1. wr_en with wr_ch == i: duty = min(wr_duty, PERIOD). Button presses in the same cycle are dropped.
  2. inc and dec pressed together: no change.
  3. inc: duty = duty+STEP if duty <= PERIOD-STEP, else PERIOD (saturate).
  4. dec: duty = duty-STEP if duty >= STEP, else 0 (saturate).
  - A wr_ch >= CHANNELS is ignored.
- Shadowing:
  - At each period boundary, shadow[i] <= duty[i] and mode_sh <= center_mode.
  - The boundary is the cycle where cnt is loaded with 0 to start a new period.
  - Duty or mode changes mid-period never alter the current period.
- Counter, edge mode (mode_sh = 0):
  - cnt runs 0,1,...,PERIOD-1 then back to 0.
  - Period = PERIOD clocks.
- Counter, center mode (mode_sh = 1):
  - cnt runs 0..PERIOD-1 up, then PERIOD-1..0 down, with each end value held for 2 cycles.
  - Period = 2*PERIOD clocks.
  - The boundary is the cycle after the down-count's second 0.
- Output compare:
  - pwm_out[i] <= (cnt < shadow[i]), registered, so one cycle of latency behind cnt.
  - duty 0 gives a constant low; duty PERIOD gives a constant high.
  - Center mode gives high time = 2*shadow, centred on the period's start/end.
- period_start:
  - Registered pulse, aligned with pwm_out for cnt == 0 at period start.
  - Once per period.
- ena low:
  - cnt held at 0, dir = up, pwm_out = 0, period_start = 0.
  - Duty updates still accepted.
  - On ena rising, a new period starts at cnt 0 with a shadow load.

Test Plan:
- Reset values: PERIOD=10, DUTY_INIT=5, ena=1, edge mode → pwm_out[0] repeats 5 high, 5 low; period_start every 10 cycles; duty_out reads 5 on each channel.
- Debounced increase: DEB_DIV=2; hold inc_btn[1] high for 6 cycles → duty[1] = 6 after exactly one press. The change appears at the next period (6 high / 4 low); other channels are unchanged.
- Saturation: 7 inc presses from duty 5 → duty stays at 10 and pwm_out is constant high. 12 dec presses → duty 0 and pwm_out is constant low.
- Collisions: simultaneous inc and dec on ch2 → no change. wr_en with wr_ch=2, wr_duty=200 in the same cycle as an inc press → duty[2] = 10.
- Center mode: center_mode=1, duty 3 → 20-cycle period. pwm_out pattern is 3 high, 14 low, 3 high. A mode switch mid-period takes effect only at the next boundary.
- ena and reset mid-operation: drop ena at cnt=4 → pwm_out goes to 0 next cycle and cnt holds at 0. Assert rst_n mid-period → all duty values return to 5 and outputs go to 0 one cycle later.
